// File: rtl/joystick_mapper_nch.sv
// N-channel joystick mapper: per-channel sync/debounce/autofire with ZXUNO config,
// merged onto the Kempston/Fuller ports and the keyboard column overlay.
module joystick_mapper_nch #(
  parameter int         NUM_CH        = 2,
  parameter int         DEB_CYCLES    = 140000,
  parameter int         DEB_W         = 18,
  parameter logic [7:0] CONF_BASE     = 8'h06,
  parameter logic [7:0] KEMPSTON_ADDR = 8'h1F,
  parameter logic [7:0] FULLER_ADDR   = 8'h7F
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           a,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  oe,
  input  logic [7:0]            zxuno_addr,
  input  logic                  zxuno_regrd,
  input  logic                  zxuno_regwr,
  input  logic [6*NUM_CH-1:0]   joy_in,
  input  logic [4:0]            kbdcol_in,
  output logic [4:0]            kbdcol_out,
  input  logic                  vretrace_n
);

  localparam int              NB       = 6 * NUM_CH;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [2:0] MODE_KEMP = 3'd1;
  localparam logic [2:0] MODE_SIN1 = 3'd2;
  localparam logic [2:0] MODE_SIN2 = 3'd3;
  localparam logic [2:0] MODE_CURS = 3'd4;
  localparam logic [2:0] MODE_FULL = 3'd5;

  logic [NB-1:0]    sync1_q, sync2_q, stable_q, stable_d;
  logic [DEB_W-1:0] deb_cnt_q [NB];
  logic [DEB_W-1:0] deb_cnt_d [NB];
  logic [7:0]       conf_q [NUM_CH];
  logic [7:0]       conf_d [NUM_CH];
  logic [3:0]       af_cnt_q [NUM_CH];
  logic [3:0]       af_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] phase_q, phase_d;
  logic             vr_q;
  logic             frame_tick_s;

  logic [5:0]        btn_s [NUM_CH];
  logic [3:0]        per_s [NUM_CH];
  logic [NUM_CH-1:0] fire_s, cfg_wr_s, cfg_hit_s;

  logic kemp_sel_s, full_sel_s, kbd_sel_s;
  logic [7:0] kemp_v_s, full_v_s, cfg_v_s;
  logic [4:0] s1_ovl_s, s2_ovl_s, c12_ovl_s, c11_ovl_s, kbd_ovl_s;
  logic unused_a_s;

  assign unused_a_s   = ^{a[15:13], a[10:8]};
  assign frame_tick_s = vretrace_n & ~vr_q;

  // Per-bit debounce: count disagreement cycles, flip the stable value on the last one.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      stable_d[b]  = stable_q[b];
      deb_cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) begin
          stable_d[b]  = sync2_q[b];
          deb_cnt_d[b] = '0;
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
        end
      end else begin
        deb_cnt_d[b] = '0;
      end
    end
  end

  // Per-channel decode of buttons, effective period, fire value and register hits.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      btn_s[ch]     = ~stable_q[6*ch +: 6];
      per_s[ch]     = (conf_q[ch][7:4] == 4'd0) ? 4'd1 : conf_q[ch][7:4];
      fire_s[ch]    = btn_s[ch][4] & (conf_q[ch][3] ? phase_q[ch] : 1'b1);
      cfg_wr_s[ch]  = zxuno_regwr & (zxuno_addr == (CONF_BASE + 8'(ch)));
      cfg_hit_s[ch] = zxuno_regrd & (zxuno_addr == (CONF_BASE + 8'(ch)));
    end
  end

  // Config register and autofire engine; a config write restarts the fire cycle.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      conf_d[ch]   = conf_q[ch];
      af_cnt_d[ch] = af_cnt_q[ch];
      phase_d[ch]  = phase_q[ch];
      if (cfg_wr_s[ch]) begin
        conf_d[ch]   = din;
        af_cnt_d[ch] = 4'd0;
        phase_d[ch]  = 1'b1;
      end else if (!(conf_q[ch][3] && btn_s[ch][4])) begin
        af_cnt_d[ch] = 4'd0;
        phase_d[ch]  = 1'b1;
      end else if (frame_tick_s) begin
        if (({1'b0, af_cnt_q[ch]} + 5'd1) == {1'b0, per_s[ch]}) begin
          af_cnt_d[ch] = 4'd0;
          phase_d[ch]  = ~phase_q[ch];
        end else begin
          af_cnt_d[ch] = af_cnt_q[ch] + 4'd1;
        end
      end else begin
        af_cnt_d[ch] = af_cnt_q[ch];
      end
    end
  end

  // Merge all channels onto each port/overlay by mode; presses win across channels.
  always_comb begin
    kemp_v_s  = 8'h00;
    full_v_s  = 8'hFF;
    cfg_v_s   = 8'h00;
    s1_ovl_s  = 5'h1F;
    s2_ovl_s  = 5'h1F;
    c12_ovl_s = 5'h1F;
    c11_ovl_s = 5'h1F;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cfg_v_s = cfg_v_s | (conf_q[ch] & {8{cfg_hit_s[ch]}});
      case (conf_q[ch][2:0])
        MODE_KEMP: kemp_v_s = kemp_v_s | {2'b00, btn_s[ch][5], fire_s[ch], btn_s[ch][3:0]};
        MODE_FULL: full_v_s = full_v_s & {~fire_s[ch], ~btn_s[ch][5], 2'b11,
                                          ~btn_s[ch][0], ~btn_s[ch][1], ~btn_s[ch][2], ~btn_s[ch][3]};
        MODE_SIN1: s1_ovl_s = s1_ovl_s & {~btn_s[ch][1], ~btn_s[ch][0], ~btn_s[ch][2],
                                          ~btn_s[ch][3], ~fire_s[ch]};
        MODE_SIN2: s2_ovl_s = s2_ovl_s & {~fire_s[ch], ~btn_s[ch][3], ~btn_s[ch][2],
                                          ~btn_s[ch][0], ~btn_s[ch][1]};
        MODE_CURS: begin
          c12_ovl_s = c12_ovl_s & {~btn_s[ch][2], ~btn_s[ch][3], ~btn_s[ch][0],
                                   ~btn_s[ch][5], ~fire_s[ch]};
          c11_ovl_s = c11_ovl_s & {~btn_s[ch][1], 4'b1111};
        end
        default: kemp_v_s = kemp_v_s;
      endcase
    end
    kbd_ovl_s = kbdcol_in
              & (a[12] ? 5'h1F : (s1_ovl_s & c12_ovl_s))
              & (a[11] ? 5'h1F : (s2_ovl_s & c11_ovl_s));
  end

  assign kemp_sel_s = ~iorq_n & ~rd_n & (a[7:0] == KEMPSTON_ADDR);
  assign full_sel_s = ~iorq_n & ~rd_n & (a[7:0] == FULLER_ADDR);
  assign kbd_sel_s  = ~iorq_n & ~rd_n & ~a[0] & ~kemp_sel_s & ~full_sel_s;

  // Read-path priority: config register, Kempston, Fuller, keyboard overlay.
  always_comb begin
    dout       = 8'hFF;
    oe         = 1'b0;
    kbdcol_out = kbdcol_in;
    if (|cfg_hit_s) begin
      dout = cfg_v_s;
      oe   = 1'b1;
    end else if (kemp_sel_s) begin
      dout = kemp_v_s;
      oe   = 1'b1;
    end else if (full_sel_s) begin
      dout = full_v_s;
      oe   = 1'b1;
    end else if (kbd_sel_s) begin
      kbdcol_out = kbd_ovl_s;
    end else begin
      kbdcol_out = kbdcol_in;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      phase_q  <= '1;
      vr_q     <= 1'b1;
      for (int b = 0; b < NB; b++) begin
        deb_cnt_q[b] <= '0;
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        af_cnt_q[ch] <= 4'd0;
        conf_q[ch]   <= (ch == 0) ? 8'h41 : ((ch == 1) ? 8'h42 : 8'h40);
      end
    end else begin
      sync1_q  <= joy_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      phase_q  <= phase_d;
      vr_q     <= vretrace_n;
      for (int b = 0; b < NB; b++) begin
        deb_cnt_q[b] <= deb_cnt_d[b];
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        af_cnt_q[ch] <= af_cnt_d[ch];
        conf_q[ch]   <= conf_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_joystick_mapper_nch.sv
// Scoreboard bench for joystick_mapper_nch with a short debounce (16 cycles).
module tb_joystick_mapper_nch;

  localparam int NUM_CH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a;
  logic        iorq_n, rd_n;
  logic [7:0]  din, dout, zxuno_addr;
  logic        oe, zxuno_regrd, zxuno_regwr, vretrace_n;
  logic [6*NUM_CH-1:0] joy;
  logic [4:0]  kbdcol_in, kbdcol_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  string       tag_q [$];
  logic [7:0]  af_pattern;

  joystick_mapper_nch #(.NUM_CH(NUM_CH), .DEB_CYCLES(16), .DEB_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .din(din),
    .dout(dout), .oe(oe), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .joy_in(joy), .kbdcol_in(kbdcol_in),
    .kbdcol_out(kbdcol_out), .vretrace_n(vretrace_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bus();
    a = 16'hFFFF; iorq_n = 1'b1; rd_n = 1'b1;
    zxuno_regrd = 1'b0; zxuno_regwr = 1'b0; zxuno_addr = 8'h00; din = 8'h00;
    kbdcol_in = 5'h1F;
  endtask

  // Drive one read cycle, push its expectation, then pop and compare the DUT response.
  task automatic drive_read(input string tag, input logic [15:0] addr, input logic cpu_rd,
                            input logic regrd, input logic [7:0] zaddr, input logic [4:0] kin,
                            input logic [7:0] exp_dout, input logic exp_oe, input logic [4:0] exp_kbd);
    logic [15:0] e;
    a = addr; iorq_n = ~cpu_rd; rd_n = ~cpu_rd;
    zxuno_regrd = regrd; zxuno_addr = zaddr; kbdcol_in = kin;
    exp_q.push_back({2'b00, exp_oe, exp_kbd, exp_dout});
    tag_q.push_back(tag);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 16'h0001, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag_q.pop_front(), {2'b00, oe, kbdcol_out, dout}, e);
    end
    idle_bus();
  endtask

  task automatic kemp_read(input string tag, input logic [7:0] exp);
    drive_read(tag, 16'h001F, 1'b1, 1'b0, 8'h00, 5'h1F, exp, 1'b1, 5'h1F);
  endtask

  task automatic conf_read(input string tag, input logic [7:0] addr, input logic [7:0] exp, input logic exp_oe);
    drive_read(tag, 16'hFFFF, 1'b0, 1'b1, addr, 5'h1F, exp, exp_oe, 5'h1F);
  endtask

  task automatic zx_write(input logic [7:0] addr, input logic [7:0] data);
    zxuno_regwr = 1'b1; zxuno_addr = addr; din = data;
    step(1);
    idle_bus();
  endtask

  task automatic frame_pulse();
    vretrace_n = 1'b0;
    step(1);
    vretrace_n = 1'b1;
    step(2);
  endtask

  initial begin
    af_pattern = 8'b0011_0011;
    idle_bus();
    joy = '1;
    vretrace_n = 1'b1;
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;

    conf_read("rst_conf0", 8'h06, 8'h41, 1'b1);
    conf_read("rst_conf1", 8'h07, 8'h42, 1'b1);
    kemp_read("rst_kemp", 8'h00);
    drive_read("rst_kbd", 16'hFEFE, 1'b1, 1'b0, 8'h00, 5'h15, 8'hFF, 1'b0, 5'h15);
    drive_read("rst_idle", 16'h001F, 1'b0, 1'b0, 8'h00, 5'h0A, 8'hFF, 1'b0, 5'h0A);

    zx_write(8'h08, 8'h00);
    conf_read("oor_read", 8'h08, 8'hFF, 1'b0);
    conf_read("oor_conf0", 8'h06, 8'h41, 1'b1);

    joy[0] = 1'b0;
    step(10);
    joy[0] = 1'b1;
    step(30);
    kemp_read("glitch_reject", 8'h00);

    joy[0] = 1'b0;
    step(17);
    kemp_read("deb_edge17", 8'h00);
    step(1);
    kemp_read("deb_edge18", 8'h01);
    step(12);
    joy[0] = 1'b1;
    step(20);
    kemp_read("deb_release", 8'h00);

    zx_write(8'h06, 8'h29);
    joy[4] = 1'b0;
    step(20);
    for (int i = 0; i < 8; i++) begin
      kemp_read($sformatf("af_frame%0d", i), af_pattern[i] ? 8'h10 : 8'h00);
      frame_pulse();
    end
    frame_pulse();
    frame_pulse();
    kemp_read("af_phase_low", 8'h00);
    joy[4] = 1'b1;
    step(20);
    kemp_read("af_released", 8'h00);
    joy[4] = 1'b0;
    step(20);
    kemp_read("af_repress", 8'h10);

    zx_write(8'h06, 8'h42);
    joy = '1;
    joy[3] = 1'b0;
    joy[7] = 1'b0;
    step(20);
    drive_read("sin1_merge", 16'hEFFE, 1'b1, 1'b0, 8'h00, 5'h1F, 8'hFF, 1'b0, 5'b01101);
    drive_read("sin2_none", 16'hF7FE, 1'b1, 1'b0, 8'h00, 5'h1F, 8'hFF, 1'b0, 5'h1F);

    zx_write(8'h07, 8'h45);
    joy = '1;
    joy[9]  = 1'b0;
    joy[10] = 1'b0;
    step(20);
    drive_read("fuller", 16'h007F, 1'b1, 1'b0, 8'h00, 5'h1F, 8'h7E, 1'b1, 5'h1F);
    drive_read("fuller_cfgprio", 16'h007F, 1'b1, 1'b1, 8'h07, 5'h1F, 8'h45, 1'b1, 5'h1F);

    zx_write(8'h06, 8'h29);
    joy = '1;
    joy[4] = 1'b0;
    step(20);
    kemp_read("mid_af_on", 8'h10);
    frame_pulse();
    frame_pulse();
    kemp_read("mid_af_toggled", 8'h00);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    conf_read("mrst_conf0", 8'h06, 8'h41, 1'b1);
    conf_read("mrst_conf1", 8'h07, 8'h42, 1'b1);
    kemp_read("mrst_kemp", 8'h00);
    step(17);
    kemp_read("mrst_edge17", 8'h00);
    step(1);
    kemp_read("mrst_edge18", 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
